// File: rtl/spi_mnrch16.sv
// 16-bit SPI monarch, mode 3 (SCLK idles high).
// One word out on MOSI, one word in from MISO per wrt pulse.
module spi_mnrch16 #(
  parameter int SCLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int HW   = $clog2(SCLK_DIV);
  localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRONT = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] BACK  = 2'd3;

  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  logic [4:0]    bcnt;
  logic [15:0]   shft;
  logic          miso_smpl;
  logic          half_end;
  logic [15:0]   shft_nxt;

  assign half_end = (hcnt == HLAST);
  assign shft_nxt = {shft[14:0], miso_smpl};
  assign MOSI     = shft[15];

  // half-period counter runs whenever a transfer is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if (state == IDLE) begin
      hcnt <= '0;
    end else if (half_end) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcnt      <= '0;
      shft      <= '0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      done      <= 1'b0;
      rd_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wrt) begin
            shft  <= wt_data;
            done  <= 1'b0;
            bcnt  <= '0;
            SS_n  <= 1'b0;
            state <= FRONT;
          end
        end
        FRONT: begin
          // first fall only opens the window, nothing shifts
          if (half_end) begin
            SCLK  <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_end) begin
            if (!SCLK) begin
              SCLK      <= 1'b1;
              miso_smpl <= MISO;
              bcnt      <= bcnt + 5'd1;
              if (bcnt == 5'd15) begin
                state <= BACK;
              end
            end else begin
              SCLK <= 1'b0;
              shft <= shft_nxt;
            end
          end
        end
        BACK: begin
          // last shift lands with SS_n release, SCLK stays high
          if (half_end) begin
            shft    <= shft_nxt;
            rd_data <= shft_nxt;
            done    <= 1'b1;
            SS_n    <= 1'b1;
            bcnt    <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mnrch16.sv
// Directed bench for spi_mnrch16: loopback, serf model,
// ignored wrt, mid-transfer reset, back-to-back, SCLK_DIV=4.
module tb_spi_mnrch16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] wt_data = '0;
  logic        sel_r = 1'b0;
  logic        loop = 1'b1;

  logic        wrt_a, wrt_b;
  logic        miso_a, miso_b;
  logic        ss_a, sclk_a, mosi_a, done_a;
  logic        ss_b, sclk_b, mosi_b, done_b;
  logic [15:0] rd_a, rd_b;

  int total = 0;
  int bad = 0;

  logic [15:0] s_word = '0;
  logic [15:0] s_tx = '0;
  logic [15:0] s_rx = '0;
  int          s_cnt = 0;
  int          rise_a = 0;
  int          rise_b = 0;
  int          viol = 0;
  logic        prev_mosi = 1'b0;
  logic        prev_ss = 1'b1;

  always #5 clk = ~clk;

  assign wrt_a  = wrt & ~sel_r;
  assign wrt_b  = wrt & sel_r;
  assign miso_a = loop ? mosi_a : s_tx[15];
  assign miso_b = mosi_b;

  spi_mnrch16 #(.SCLK_DIV(16)) u_a (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_a), .wt_data(wt_data),
    .MISO(miso_a), .SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .done(done_a), .rd_data(rd_a)
  );

  spi_mnrch16 #(.SCLK_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_b), .wt_data(wt_data),
    .MISO(miso_b), .SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .done(done_b), .rd_data(rd_b)
  );

  wire        ss_x   = sel_r ? ss_b : ss_a;
  wire        sclk_x = sel_r ? sclk_b : sclk_a;
  wire        done_x = sel_r ? done_b : done_a;
  wire [15:0] rd_x   = sel_r ? rd_b : rd_a;

  always @(posedge sclk_a) rise_a++;
  always @(posedge sclk_b) rise_b++;

  // serf: shifts out on fall (after first rise), captures on rise
  always @(negedge ss_a) begin
    s_tx  = s_word;
    s_cnt = 0;
  end
  always @(posedge sclk_a) if (!ss_a) begin
    s_rx = {s_rx[14:0], mosi_a};
    s_cnt++;
  end
  always @(negedge sclk_a) if (!ss_a && s_cnt > 0)
    s_tx = {s_tx[14:0], 1'b0};

  always @(negedge clk) begin
    if (mosi_a !== prev_mosi && sclk_a && !ss_a && !prev_ss)
      viol++;
    prev_mosi = mosi_a;
    prev_ss   = ss_a;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit sel, input logic [15:0] d,
                      input bit b2b, input int glitch,
                      output int low, output int rises,
                      output int lo);
    if (!b2b) @(negedge clk);
    sel_r = sel;
    rise_a = 0;
    rise_b = 0;
    wrt = 1'b1;
    wt_data = d;
    @(negedge clk);
    wrt = 1'b0;
    wt_data = ~d;
    chk("done_clr", {31'd0, done_x}, 32'd0);
    low = 0;
    lo = 0;
    while (ss_x == 1'b0 && low < 400) begin
      low++;
      if (!sclk_x) lo++;
      if (low == glitch) begin
        wrt = 1'b1;
        wt_data = 16'hFFFF;
      end else begin
        wrt = 1'b0;
        wt_data = ~d;
      end
      @(negedge clk);
    end
    wrt = 1'b0;
    rises = sel ? rise_b : rise_a;
  endtask

  int low, rises, lo;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss", {31'd0, ss_a}, 32'd1);
    chk("rst_sclk", {31'd0, sclk_a}, 32'd1);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_rd", {16'd0, rd_a}, 32'd0);
    chk("rst_mosi", {31'd0, mosi_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    loop = 1'b1;
    xfer(0, 16'hA5C3, 0, -1, low, rises, lo);
    chk("lb_low", low, 264);
    chk("lb_rises", rises, 16);
    chk("lb_sclk_lo", lo, 128);
    chk("lb_done", {31'd0, done_a}, 32'd1);
    chk("lb_rd", {16'd0, rd_a}, 32'hA5C3);

    loop = 1'b0;
    s_word = 16'h1234;
    viol = 0;
    xfer(0, 16'hA600, 0, -1, low, rises, lo);
    chk("srf_low", low, 264);
    chk("srf_rx", {16'd0, s_rx}, 32'hA600);
    chk("srf_mosi_stable", viol, 0);
    chk("srf_rd", {16'd0, rd_a}, 32'h1234);
    repeat (20) @(negedge clk);
    chk("srf_hold_rd", {16'd0, rd_a}, 32'h1234);
    chk("srf_hold_done", {31'd0, done_a}, 32'd1);

    loop = 1'b1;
    xfer(0, 16'h3C5A, 0, 50, low, rises, lo);
    chk("ign_low", low, 264);
    chk("ign_rises", rises, 16);
    chk("ign_rd", {16'd0, rd_a}, 32'h3C5A);

    @(negedge clk);
    wrt = 1'b1;
    wt_data = 16'h5555;
    @(negedge clk);
    wrt = 1'b0;
    repeat (99) @(negedge clk);
    chk("mid_ss_low", {31'd0, ss_a}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_ss", {31'd0, ss_a}, 32'd1);
    chk("mr_sclk", {31'd0, sclk_a}, 32'd1);
    chk("mr_done", {31'd0, done_a}, 32'd0);
    chk("mr_rd", {16'd0, rd_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 16'h0D02, 0, -1, low, rises, lo);
    chk("ar_low", low, 264);
    chk("ar_done", {31'd0, done_a}, 32'd1);
    chk("ar_rd", {16'd0, rd_a}, 32'h0D02);

    xfer(0, 16'h1111, 0, -1, low, rises, lo);
    chk("b2b1_rd", {16'd0, rd_a}, 32'h1111);
    xfer(0, 16'h7E81, 1, -1, low, rises, lo);
    chk("b2b2_low", low, 264);
    chk("b2b2_done", {31'd0, done_a}, 32'd1);
    chk("b2b2_rd", {16'd0, rd_a}, 32'h7E81);

    xfer(1, 16'h8001, 0, -1, low, rises, lo);
    chk("d4_low", low, 66);
    chk("d4_rises", rises, 16);
    chk("d4_sclk_lo", lo, 32);
    chk("d4_done", {31'd0, done_b}, 32'd1);
    chk("d4_rd", {16'd0, rd_b}, 32'h8001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mnrch16.md
Name: spi_mnrch16

Overview:
- 16-bit SPI monarch that carries every command and readback between the inertial interface state machine and the inertial sensor.
- The upstream interface block presents a command word (for example 16'h0D02 for INT enable, or 16'hA600 for a yawL read) and pulses wrt.
- This block serializes the word on MOSI, captures MISO, and returns the 16 received bits with a sticky done flag.
- SCLK idles high, MOSI changes on SCLK fall, MISO is sampled on SCLK rise (mode 3).

Parameters:
- SCLK_DIV, 16: clk cycles per SCLK period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- wrt  input  1  one-clk pulse; starts a transaction with wt_data.
- wt_data  input  16  command/data word to send, MSB first.
- MISO  input  1  serial data from serf.
- SS_n  output  1  serf select, active-low.
- SCLK  output  1  serial clock, idles high.
- MOSI  output  1  serial data to serf, equals shift register bit 15.
- done  output  1  sticky; set when a transaction completes, cleared by the next accepted wrt.
- rd_data  output  16  bits received in the last transaction, MSB first.

Behaviour:
- Reset values:
  - SS_n=1, SCLK=1, done=0, rd_data=16'h0000.
  - Shift register=0, so MOSI=0.
  - State=IDLE, counters=0.
- States and transitions:
  - IDLE: SS_n=1, SCLK=1. wrt=1 loads wt_data into the shift register, clears done, zeroes the SCLK counter, and goes to FRONT. SS_n falls on the next clk edge.
  - FRONT (front porch): SS_n=0, SCLK=1 for SCLK_DIV/2 clks, then SCLK falls. This first fall performs no shift. Go to SHIFT.
  - SHIFT: SCLK is low for SCLK_DIV/2 clks, then high for SCLK_DIV/2 clks.
    - On the clk where SCLK rises, MISO is captured into a sample flop.
    - On each subsequent clk where SCLK would fall, the shift register does {shft[14:0], miso_smpl}.
    - A 5-bit bit counter increments on each rise. After the 16th rise, go to BACK.
  - BACK (back porch): SCLK stays high.
    - SCLK_DIV/2 clks after the 16th rise, the final shift occurs and SS_n returns high.
    - In the same cycle, done is set and rd_data gets the shifted word. Go to IDLE.
- Timing:
  - SS_n low duration: SCLK_DIV/2 + 16*SCLK_DIV clks (264 at default).
  - wrt to SS_n fall: 1 clk.
  - SCLK edges per transaction: exactly 16 rising and 16 falling. No glitches; SCLK is registered.
- MOSI:
  - Bit 15 of wt_data is valid from SS_n fall.
  - Each subsequent bit is valid from its SCLK fall and stable across the following SCLK rise.
- rd_data and done:
  - rd_data is updated only at completion and holds between transactions.
  - done stays high until the next accepted wrt.
- Boundary conditions:
  - wrt while not IDLE: ignored. No reload, no effect on done or the transfer.
  - wrt in the IDLE cycle immediately after completion: accepted. done clears on the next edge and the new transaction starts.
  - wt_data changing after the wrt cycle: no effect.
  - rst_n asserted mid-transaction: all outputs go to reset values immediately, and no partial rd_data update occurs.
  - Counter widths are sized from SCLK_DIV (clog2). Counters do not wrap within a transaction.

Test Plan:
- Loopback test (MOSI tied to MISO), wt_data=16'hA5C3, SCLK_DIV=16:
  - Expect SS_n low for 264 clks and exactly 16 SCLK rises.
  - Expect done=1 with rd_data=16'hA5C3 on the cycle SS_n rises.
- Serf model returning 16'h1234 with wt_data=16'hA600:
  - Serf sees 16'hA600 MSB first, and MOSI is stable at every SCLK rise.
  - Expect rd_data=16'h1234 and done=1, both held until the next wrt.
- wrt pulsed again 50 clks into a transfer with wt_data=16'hFFFF:
  - Transfer completes unchanged with the original data.
  - SS_n low duration is still 264 clks.
- rst_n asserted 100 clks into a transfer:
  - SS_n=1, SCLK=1, done=0, rd_data=0 immediately.
  - After release, a new wrt with 16'h0D02 completes normally.
- Back-to-back: wrt pulsed on the first IDLE cycle after done:
  - done clears one clk later.
  - SS_n is high for exactly 1 clk between transactions.
  - Second rd_data is correct.
- SCLK_DIV=4 with loopback and 16'h8001:
  - SS_n low for 66 clks, SCLK period of 4 clks.
  - Expect rd_data=16'h8001.
